// File: rtl/angle_rx_pkg.sv
// Shared types and constants for the Arduino angle receiver.
// Build option: ANGLE_RX_CHECKSUM_EN adds a trailing checksum byte to each frame.
package angle_rx_pkg;

    typedef enum logic [1:0] {
        WAIT_HDR = 2'd0,
        GET_LO   = 2'd1,
        GET_HI   = 2'd2,
        GET_CHK  = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

`ifdef ANGLE_RX_CHECKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    // State in which the final byte of a frame arrives.
    localparam frame_state_t LAST_STATE = (FRAME_LEN == 4) ? GET_CHK : GET_HI;

    function automatic logic frame_done(frame_state_t st);
        return st == LAST_STATE;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, half-bit start qualification,
// mid-bit sampling of data and stop bits.
module uart_rx_byte
    import angle_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_async,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d, err_q, err_d;
    logic            cnt_zero;

    assign cnt_zero   = (cnt_q == '0);
    assign rx_byte    = shift_q;
    assign byte_valid = valid_q;
    assign byte_err   = err_q;

    // Bit FSM: down-counter reaching zero marks each sampling point.
    always_comb begin
        sync1_d = rx_async;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (sync2_q) begin
                    state_d = IDLE;             // glitch, not a real start bit
                end else begin
                    state_d = DATA;
                    cnt_d   = FULL_LOAD;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    valid_d = sync2_q;
                    err_d   = !sync2_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registers; synchronizer and edge detector reset to the idle-high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/arduino_angle_rx.sv
// Frames the Arduino byte stream into validated 16-bit angles for the PID.
// Build option: ANGLE_RX_CHECKSUM_EN enables the GET_CHK checksum byte.
//
// state    | meaning
// WAIT_HDR | hunting for the header byte, other bytes dropped silently
// GET_LO   | expecting angle low byte
// GET_HI   | expecting angle high byte
// GET_CHK  | expecting checksum byte (checksum build only)
module arduino_angle_rx
    import angle_rx_pkg::*;
#(
    parameter int          SIZE         = 16,
    parameter int          CLK_HZ       = 100_000_000,
    parameter int          BAUD         = 9600,
    parameter logic [7:0]  HEADER       = HEADER_DEFAULT,
    parameter logic [15:0] MAX_ANGLE    = 16'd359,
    parameter logic [31:0] BYTE_TIMEOUT = 32'd200_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            serialFromArduino,
    output logic [SIZE-1:0] data,
    output logic            isDataReady,
    output logic            frameError
);
    logic [7:0]      rx_byte;
    logic            byte_valid, byte_err;

    frame_state_t    state_q, state_d;
    logic [7:0]      lo_q, lo_d;
`ifdef ANGLE_RX_CHECKSUM_EN
    logic [7:0]      hi_q, hi_d;
`endif
    logic [31:0]     tmo_q, tmo_d;
    logic [SIZE-1:0] data_q, data_d;
    logic            rdy_q, rdy_d, ferr_q, ferr_d;
    logic [15:0]     angle;
    logic            commit, chk_ok;

    uart_rx_byte #(.CLKS_PER_BIT(CLK_HZ / BAUD)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_async   (serialFromArduino),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .byte_err   (byte_err)
    );

    assign data        = data_q;
    assign isDataReady = rdy_q;
    assign frameError  = ferr_q;

    // Frame FSM, inter-byte timeout and commit decision; outputs are registered.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
`ifdef ANGLE_RX_CHECKSUM_EN
        hi_d    = hi_q;
`endif
        data_d  = data_q;
        rdy_d   = 1'b0;
        ferr_d  = 1'b0;
        angle   = 16'h0000;
        commit  = 1'b0;
        chk_ok  = 1'b1;
        tmo_d   = (state_q == WAIT_HDR || byte_valid) ? 32'd0 : tmo_q + 32'd1;

        if (state_q != WAIT_HDR && byte_err) begin
            ferr_d  = 1'b1;
            state_d = WAIT_HDR;
        end else if (byte_valid) begin
            case (state_q)
                WAIT_HDR: if (rx_byte == HEADER) state_d = GET_LO;
                GET_LO: begin
                    lo_d    = rx_byte;
                    state_d = GET_HI;
                end
                GET_HI: begin
                    angle = {rx_byte, lo_q};
`ifdef ANGLE_RX_CHECKSUM_EN
                    hi_d  = rx_byte;
`endif
                    if (frame_done(state_q)) commit = 1'b1;
                    else                     state_d = GET_CHK;
                end
`ifdef ANGLE_RX_CHECKSUM_EN
                GET_CHK: begin
                    angle  = {hi_q, lo_q};
                    chk_ok = (rx_byte == (HEADER ^ lo_q ^ hi_q));
                    commit = 1'b1;
                end
`endif
                default: state_d = WAIT_HDR;
            endcase
        end else if (state_q != WAIT_HDR && tmo_q == BYTE_TIMEOUT) begin
            ferr_d  = 1'b1;
            state_d = WAIT_HDR;
        end

        if (commit) begin
            state_d = WAIT_HDR;
            if (chk_ok && angle <= MAX_ANGLE) begin
                data_d = SIZE'(angle);
                rdy_d  = 1'b1;
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_HDR;
            lo_q    <= 8'h00;
`ifdef ANGLE_RX_CHECKSUM_EN
            hi_q    <= 8'h00;
`endif
            tmo_q   <= 32'd0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
`ifdef ANGLE_RX_CHECKSUM_EN
            hi_q    <= hi_d;
`endif
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: tb/tb_arduino_angle_rx.sv
// Directed bench for arduino_angle_rx with a shortened bit time (16 clk/bit)
// and a short inter-byte timeout so every scenario stays quick.
module tb_arduino_angle_rx;
    localparam int CPB = 16;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        line = 1'b1;
    logic [15:0] data;
    logic        isDataReady;
    logic        frameError;

    int passed = 0;
    int total  = 0;

    int rdy_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    logic rdy_prev = 1'b0;

    always #5 clk = ~clk;

    arduino_angle_rx #(
        .SIZE(16), .CLK_HZ(160_000), .BAUD(10_000), .HEADER(8'hA5),
        .MAX_ANGLE(16'd359), .BYTE_TIMEOUT(32'd2000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .serialFromArduino (line),
        .data              (data),
        .isDataReady       (isDataReady),
        .frameError        (frameError)
    );

    // Pulse monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (isDataReady) rdy_cnt++;
        if (frameError) err_cnt++;
        if (isDataReady && frameError) both_cnt++;
        if (isDataReady && rdy_prev) wide_cnt++;
        rdy_prev = isDataReady;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            idle(CPB);
        end
        line = stop;
        idle(CPB);
        line = 1'b1;
    endtask

    task automatic send_frame_nogap(input logic [7:0] lo, input logic [7:0] hi);
        send_byte(8'hA5, 1'b1);
        send_byte(lo, 1'b1);
        send_byte(hi, 1'b1);
`ifdef ANGLE_RX_CHECKSUM_EN
        send_byte(8'hA5 ^ lo ^ hi, 1'b1);
`endif
    endtask

    task automatic send_frame(input logic [7:0] lo, input logic [7:0] hi);
        send_frame_nogap(lo, hi);
        idle(8);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(5);
        total++; if (data !== 16'd0) $display("FAIL reset_data: got %0d want 0", data); else passed++;
        total++; if (isDataReady !== 1'b0) $display("FAIL reset_rdy: got %b want 0", isDataReady); else passed++;
        total++; if (frameError !== 1'b0) $display("FAIL reset_err: got %b want 0", frameError); else passed++;
        rst = 1'b0;
        idle(20);
    endtask

    task automatic test_basic;
        int r0, e0;
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'hB4, 8'h00);
        total++; if (data !== 16'd180) $display("FAIL basic_data: got %0d want 180", data); else passed++;
        total++; if (rdy_cnt - r0 !== 1) $display("FAIL basic_rdy_pulses: got %0d want 1", rdy_cnt - r0); else passed++;
        total++; if (err_cnt - e0 !== 0) $display("FAIL basic_err_pulses: got %0d want 0", err_cnt - e0); else passed++;
        total++; if (wide_cnt !== 0) $display("FAIL basic_rdy_width: got %0d wide cycles want 0", wide_cnt); else passed++;
    endtask

    task automatic test_resync;
        int r0, e0;
        r0 = rdy_cnt; e0 = err_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'h7F, 1'b1);
        send_frame(8'h5A, 8'h00);
        total++; if (data !== 16'd90) $display("FAIL resync_data: got %0d want 90", data); else passed++;
        total++; if (rdy_cnt - r0 !== 1) $display("FAIL resync_rdy_pulses: got %0d want 1", rdy_cnt - r0); else passed++;
        total++; if (err_cnt - e0 !== 0) $display("FAIL resync_err_pulses: got %0d want 0", err_cnt - e0); else passed++;
    endtask

    task automatic test_range;
        int r0, e0;
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'h68, 8'h01);
        total++; if (data !== 16'd90) $display("FAIL range360_data: got %0d want 90", data); else passed++;
        total++; if (err_cnt - e0 !== 1) $display("FAIL range360_err_pulses: got %0d want 1", err_cnt - e0); else passed++;
        total++; if (rdy_cnt - r0 !== 0) $display("FAIL range360_rdy_pulses: got %0d want 0", rdy_cnt - r0); else passed++;
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'h67, 8'h01);
        total++; if (data !== 16'd359) $display("FAIL range359_data: got %0d want 359", data); else passed++;
        total++; if (rdy_cnt - r0 !== 1) $display("FAIL range359_rdy_pulses: got %0d want 1", rdy_cnt - r0); else passed++;
        total++; if (err_cnt - e0 !== 0) $display("FAIL range359_err_pulses: got %0d want 0", err_cnt - e0); else passed++;
    endtask

    task automatic test_header_as_data;
        send_frame(8'hA5, 8'h00);
        total++; if (data !== 16'd165) $display("FAIL hdr_as_data: got %0d want 165", data); else passed++;
    endtask

    task automatic test_timeout;
        int r0, e0;
        r0 = rdy_cnt; e0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h2D, 1'b1);
        idle(2500);
        total++; if (err_cnt - e0 !== 1) $display("FAIL timeout_err_pulses: got %0d want 1", err_cnt - e0); else passed++;
        send_byte(8'h00, 1'b1);
        idle(8);
        total++; if (data !== 16'd165) $display("FAIL timeout_trailing_data: got %0d want 165", data); else passed++;
        send_frame(8'h0A, 8'h00);
        total++; if (data !== 16'd10) $display("FAIL timeout_recover_data: got %0d want 10", data); else passed++;
        total++; if (rdy_cnt - r0 !== 1) $display("FAIL timeout_rdy_pulses: got %0d want 1", rdy_cnt - r0); else passed++;
        total++; if (err_cnt - e0 !== 1) $display("FAIL timeout_err_total: got %0d want 1", err_cnt - e0); else passed++;
    endtask

    task automatic test_stop_err;
        int r0, e0;
        r0 = rdy_cnt; e0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'hB4, 1'b0);
        idle(40);
        total++; if (err_cnt - e0 !== 1) $display("FAIL stoperr_err_pulses: got %0d want 1", err_cnt - e0); else passed++;
        total++; if (data !== 16'd10) $display("FAIL stoperr_data: got %0d want 10", data); else passed++;
        e0 = err_cnt;
        send_byte(8'h33, 1'b0);
        idle(40);
        line = 1'b0;
        idle(CPB / 4);
        line = 1'b1;
        idle(60);
        total++; if (err_cnt - e0 !== 0) $display("FAIL idle_err_glitch_pulses: got %0d want 0", err_cnt - e0); else passed++;
        total++; if (rdy_cnt - r0 !== 0) $display("FAIL idle_err_glitch_rdy: got %0d want 0", rdy_cnt - r0); else passed++;
        send_frame(8'hB4, 8'h00);
        total++; if (data !== 16'd180) $display("FAIL stoperr_recover_data: got %0d want 180", data); else passed++;
    endtask

    task automatic test_back_to_back;
        int r0, e0;
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame_nogap(8'h10, 8'h00);
        send_frame(8'h20, 8'h00);
        total++; if (data !== 16'd32) $display("FAIL b2b_data: got %0d want 32", data); else passed++;
        total++; if (rdy_cnt - r0 !== 2) $display("FAIL b2b_rdy_pulses: got %0d want 2", rdy_cnt - r0); else passed++;
        total++; if (err_cnt - e0 !== 0) $display("FAIL b2b_err_pulses: got %0d want 0", err_cnt - e0); else passed++;
    endtask

`ifdef ANGLE_RX_CHECKSUM_EN
    task automatic test_checksum;
        int r0, e0;
        r0 = rdy_cnt; e0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'hB4, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        idle(8);
        total++; if (data !== 16'd180) $display("FAIL chk_good_data: got %0d want 180", data); else passed++;
        total++; if (rdy_cnt - r0 !== 1) $display("FAIL chk_good_rdy: got %0d want 1", rdy_cnt - r0); else passed++;
        send_frame(8'h05, 8'h00);
        r0 = rdy_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'hB4, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b1);
        idle(8);
        total++; if (data !== 16'd5) $display("FAIL chk_bad_data: got %0d want 5", data); else passed++;
        total++; if (err_cnt - e0 !== 1) $display("FAIL chk_bad_err: got %0d want 1", err_cnt - e0); else passed++;
        total++; if (rdy_cnt - r0 !== 0) $display("FAIL chk_bad_rdy: got %0d want 0", rdy_cnt - r0); else passed++;
    endtask
`endif

    task automatic test_rst_mid_frame;
        int r0, e0;
        send_frame(8'h2C, 8'h01);
        total++; if (data !== 16'd300) $display("FAIL prerst_data: got %0d want 300", data); else passed++;
        r0 = rdy_cnt; e0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'hB4, 1'b1);
        line = 1'b0;
        idle(3 * CPB);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        line = 1'b1;
        idle(300);
        total++; if (data !== 16'd0) $display("FAIL rst_mid_data: got %0d want 0", data); else passed++;
        total++; if (rdy_cnt - r0 !== 0) $display("FAIL rst_mid_rdy: got %0d want 0", rdy_cnt - r0); else passed++;
        total++; if (err_cnt - e0 !== 0) $display("FAIL rst_mid_err: got %0d want 0", err_cnt - e0); else passed++;
        send_frame(8'h2D, 8'h00);
        total++; if (data !== 16'd45) $display("FAIL postrst_data: got %0d want 45", data); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resync();
        test_range();
        test_header_as_data();
        test_timeout();
        test_stop_err();
        test_back_to_back();
`ifdef ANGLE_RX_CHECKSUM_EN
        test_checksum();
`endif
        test_rst_mid_frame();
        total++; if (both_cnt !== 0) $display("FAIL rdy_err_overlap: got %0d want 0", both_cnt); else passed++;
        total++; if (wide_cnt !== 0) $display("FAIL rdy_pulse_width: got %0d wide cycles want 0", wide_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
